// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: bus widths, command/client enums,
// issue-register and tag-table entry layouts.
package mem_port_arbiter_pkg;

  localparam int ADDR_W       = 32;
  localparam int BLOCK_W      = 64;
  localparam int TAG_W        = 4;
  localparam int NUM_MEM_TAGS = 15;
  localparam int MEM_MAX_OUT  = 4;
  localparam int CNT_W        = 4;
  localparam int NUM_LD       = 3;

  typedef logic [ADDR_W-1:0]  ADDR;
  typedef logic [BLOCK_W-1:0] MEM_BLOCK;
  typedef logic [TAG_W-1:0]   MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic [1:0] {
    CL_Q = 2'd0,
    CL_K = 2'd1,
    CL_V = 2'd2,
    CL_O = 2'd3
  } MEM_CLIENT_T;

  typedef struct packed {
    logic        vld;
    MEM_CLIENT_T client;
    ADDR         addr;
    MEM_BLOCK    data;
  } issue_t;

  typedef struct packed {
    logic        vld;
    MEM_CLIENT_T owner;
  } tag_entry_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter4.sv
// Four-way round-robin arbiter: one-hot grant searched starting after the
// last granted requester; the pointer moves only when advance is strobed.
module rr_arbiter4
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  input  logic       adv_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_idx_o
);

  logic [1:0] last_q;
  logic [1:0] last_d;
  logic [1:0] idx;

  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    idx    = '0;
    // k = 4 wraps back to last_q itself, so it is searched last
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (req_i[idx] && (gnt_o == 4'b0000)) begin
        gnt_o[idx] = 1'b1;
        last_d     = idx;
      end
    end
  end

  assign gnt_idx_o = last_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= 2'(CL_O);
    end else if (adv_i && (gnt_o != 4'b0000)) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the tagged memory port among Q/K/V load streams and the O store
// stream; retries rejected commands and routes returning data by tag owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUT = MEM_MAX_OUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LD-1:0]           ld_req_vld,
  input  logic [NUM_LD*ADDR_W-1:0]    ld_req_addr,
  output logic [NUM_LD-1:0]           ld_req_rdy,
  input  logic                        st_req_vld,
  input  logic [ADDR_W-1:0]           st_req_addr,
  input  logic [BLOCK_W-1:0]          st_req_data,
  output logic                        st_req_rdy,
  output logic [NUM_LD-1:0]           ld_rsp_vld,
  output logic [BLOCK_W-1:0]          ld_rsp_data,
  output logic [1:0]                  proc2mem_command,
  output logic [ADDR_W-1:0]           proc2mem_addr,
  output logic [BLOCK_W-1:0]          proc2mem_data,
  input  logic [TAG_W-1:0]            mem2proc_transaction_tag,
  input  logic [BLOCK_W-1:0]          mem2proc_data,
  input  logic [TAG_W-1:0]            mem2proc_data_tag,
  output logic                        idle,
  output logic                        err
);

  // Handshake: a request transfers in the cycle where vld && rdy; rdy is a
  // combinational function of vld, the transaction tag and state only.

  issue_t      iss_q, iss_d;
  tag_entry_t  tag_q [NUM_MEM_TAGS+1];
  tag_entry_t  tag_d [NUM_MEM_TAGS+1];
  logic [CNT_W-1:0] cnt_q [NUM_LD];
  logic [CNT_W-1:0] cnt_d [NUM_LD];
  logic [NUM_LD-1:0] rsp_vld_q, rsp_vld_d;
  MEM_BLOCK    rsp_data_q, rsp_data_d;
  logic        err_q, err_d;

  MEM_TAG      acc_tag;
  MEM_TAG      rsp_tag;
  logic        accept;
  logic        acc_load;
  logic        rsp_hit;
  logic        rsp_miss;
  MEM_CLIENT_T rsp_owner;
  logic        can_fill;
  logic [NUM_LD-1:0] ld_elig;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [1:0]  gnt_idx;
  MEM_CLIENT_T gnt_cl;
  ADDR         gnt_addr;

  assign acc_tag   = mem2proc_transaction_tag;
  assign rsp_tag   = mem2proc_data_tag;
  assign accept    = iss_q.vld && (acc_tag != '0);
  assign acc_load  = accept && (iss_q.client != CL_O);
  assign rsp_hit   = (rsp_tag != '0) && tag_q[rsp_tag].vld;
  assign rsp_miss  = (rsp_tag != '0) && !tag_q[rsp_tag].vld;
  assign rsp_owner = tag_q[rsp_tag].owner;
  assign can_fill  = !iss_q.vld || accept;

  // A load sitting in the issue register counts toward its client's limit,
  // otherwise back-to-back grants could push outstanding loads past MAX_OUT.
  always_comb begin
    ld_elig = '0;
    for (int i = 0; i < NUM_LD; i++) begin
      ld_elig[i] = ld_req_vld[i] &&
                   (({1'b0, cnt_q[i]} +
                     (CNT_W+1)'(iss_q.vld && (iss_q.client == 2'(i))))
                    < (CNT_W+1)'(MAX_OUT));
    end
  end

  assign req = can_fill ? {st_req_vld, ld_elig} : 4'b0000;

  rr_arbiter4 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .adv_i     (can_fill),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign ld_req_rdy = gnt[NUM_LD-1:0];
  assign st_req_rdy = gnt[3];
  assign gnt_cl     = MEM_CLIENT_T'(gnt_idx);

  always_comb begin
    case (gnt_cl)
      CL_Q:    gnt_addr = ld_req_addr[0*ADDR_W +: ADDR_W];
      CL_K:    gnt_addr = ld_req_addr[1*ADDR_W +: ADDR_W];
      CL_V:    gnt_addr = ld_req_addr[2*ADDR_W +: ADDR_W];
      default: gnt_addr = st_req_addr;
    endcase
  end

  always_comb begin
    iss_d = iss_q;
    if (accept) begin
      iss_d.vld = 1'b0;
    end
    if (gnt != 4'b0000) begin
      iss_d.vld    = 1'b1;
      iss_d.client = gnt_cl;
      iss_d.addr   = gnt_addr;
      iss_d.data   = (gnt_cl == CL_O) ? st_req_data : '0;
    end
  end

  // Response frees its entry before acceptance allocates, so a tag that is
  // returned and re-issued in the same cycle is not a protocol error.
  always_comb begin
    tag_d      = tag_q;
    err_d      = err_q;
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    if (rsp_hit) begin
      tag_d[rsp_tag].vld = 1'b0;
      rsp_data_d         = mem2proc_data;
      for (int i = 0; i < NUM_LD; i++) begin
        rsp_vld_d[i] = (rsp_owner == 2'(i));
      end
    end
    if (rsp_miss) begin
      err_d = 1'b1;
    end
    if (acc_load) begin
      if (tag_d[acc_tag].vld) begin
        err_d = 1'b1;
      end
      tag_d[acc_tag].vld   = 1'b1;
      tag_d[acc_tag].owner = iss_q.client;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LD; i++) begin
      cnt_d[i] = cnt_q[i]
               + CNT_W'(acc_load && (iss_q.client == 2'(i)))
               - CNT_W'(rsp_hit && (rsp_owner == 2'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      iss_q      <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      for (int t = 0; t <= NUM_MEM_TAGS; t++) begin
        tag_q[t] <= '0;
      end
      for (int i = 0; i < NUM_LD; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      iss_q      <= iss_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      for (int t = 0; t <= NUM_MEM_TAGS; t++) begin
        tag_q[t] <= tag_d[t];
      end
      for (int i = 0; i < NUM_LD; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (iss_q.vld) begin
      proc2mem_command = (iss_q.client == CL_O) ? MEM_STORE : MEM_LOAD;
      proc2mem_addr    = iss_q.addr;
      proc2mem_data    = iss_q.data;
    end
  end

  assign ld_rsp_vld  = rsp_vld_q;
  assign ld_rsp_data = rsp_data_q;
  assign err         = err_q;
  assign idle        = !iss_q.vld && (cnt_q[0] == '0) && (cnt_q[1] == '0)
                       && (cnt_q[2] == '0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter: one vector per clock with
// hand-computed expected outputs; optional reset before a vector.
module tb_mem_port_arbiter;

  localparam logic [31:0] QA = 32'h0000_0100;
  localparam logic [31:0] KA = 32'h0000_0200;
  localparam logic [31:0] VA = 32'h0000_0300;
  localparam logic [31:0] OA = 32'h0000_0400;
  localparam logic [63:0] ST_D = 64'h5A5A_0000_1234_5678;
  localparam logic [1:0] C_N = 2'h0;
  localparam logic [1:0] C_L = 2'h1;
  localparam logic [1:0] C_S = 2'h2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ld_req_vld;
  logic [95:0] ld_req_addr;
  logic [2:0]  ld_req_rdy;
  logic        st_req_vld;
  logic [31:0] st_req_addr;
  logic [63:0] st_req_data;
  logic        st_req_rdy;
  logic [2:0]  ld_rsp_vld;
  logic [63:0] ld_rsp_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_transaction_tag;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_data_tag;
  logic        idle;
  logic        err;

  mem_port_arbiter #(.MAX_OUT(4)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .ld_req_vld               (ld_req_vld),
    .ld_req_addr              (ld_req_addr),
    .ld_req_rdy               (ld_req_rdy),
    .st_req_vld               (st_req_vld),
    .st_req_addr              (st_req_addr),
    .st_req_data              (st_req_data),
    .st_req_rdy               (st_req_rdy),
    .ld_rsp_vld               (ld_rsp_vld),
    .ld_rsp_data              (ld_rsp_data),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .proc2mem_data            (proc2mem_data),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data            (mem2proc_data),
    .mem2proc_data_tag        (mem2proc_data_tag),
    .idle                     (idle),
    .err                      (err)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_first;
    logic [2:0]  ld;
    logic        st;
    logic [3:0]  txn;
    logic [3:0]  dtag;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [2:0]  e_ldrdy;
    logic        e_strdy;
    logic [2:0]  e_rsp;
    logic [3:0]  e_rtag;
    logic        e_idle;
    logic        e_err;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;
  int   cur_vec = 0;

  function automatic logic [63:0] mdata(input logic [3:0] tag);
    return 64'hC0DE_0000_0000_0000 | {60'h0, tag};
  endfunction

  function automatic void add(input logic rf, input logic [2:0] ld, input logic st,
                              input logic [3:0] txn, input logic [3:0] dtag,
                              input logic [1:0] cmd, input logic [31:0] addr,
                              input logic [2:0] ldrdy, input logic strdy,
                              input logic [2:0] rsp, input logic [3:0] rtag,
                              input logic e_idle, input logic e_err);
    vec_t v;
    v.rst_first = rf; v.ld = ld; v.st = st; v.txn = txn; v.dtag = dtag;
    v.e_cmd = cmd; v.e_addr = addr; v.e_ldrdy = ldrdy; v.e_strdy = strdy;
    v.e_rsp = rsp; v.e_rtag = rtag; v.e_idle = e_idle; v.e_err = e_err;
    vq.push_back(v);
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d act=%h exp=%h", name, cur_vec, act, exp);
    end
  endtask

  // driver
  task automatic drive(input vec_t v);
    ld_req_vld               = v.ld;
    st_req_vld               = v.st;
    mem2proc_transaction_tag = v.txn;
    mem2proc_data_tag        = v.dtag;
    mem2proc_data            = mdata(v.dtag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_rsp_data", ld_rsp_data, 64'h0);
  endtask

  initial begin
    rst = 1'b0;
    ld_req_vld = '0; st_req_vld = 1'b0;
    ld_req_addr = {VA, KA, QA};
    st_req_addr = OA;
    st_req_data = ST_D;
    mem2proc_transaction_tag = '0; mem2proc_data_tag = '0; mem2proc_data = '0;

    //  rf  ld    st txn dtg cmd  addr ldrdy st rsp   rt idle err
    // single Q load, tag 3, response routed to Q
    add(1, 3'b001, 0, 0, 0, C_N, 0,  3'b001, 0, 3'b000, 0, 1, 0);
    add(0, 3'b000, 0, 3, 0, C_L, QA, 3'b000, 0, 3'b000, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, C_N, 0,  3'b000, 0, 3'b000, 0, 0, 0);
    add(0, 3'b000, 0, 0, 3, C_N, 0,  3'b000, 0, 3'b000, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, C_N, 0,  3'b000, 0, 3'b001, 3, 1, 0);
    add(0, 3'b000, 0, 0, 0, C_N, 0,  3'b000, 0, 3'b000, 0, 1, 0);
    // all four requesting, memory always accepts: Q,K,V,O,Q back to back
    add(1, 3'b111, 1, 0, 0, C_N, 0,  3'b001, 0, 3'b000, 0, 1, 0);
    add(0, 3'b111, 1, 1, 0, C_L, QA, 3'b010, 0, 3'b000, 0, 0, 0);
    add(0, 3'b111, 1, 2, 0, C_L, KA, 3'b100, 0, 3'b000, 0, 0, 0);
    add(0, 3'b111, 1, 4, 0, C_L, VA, 3'b000, 1, 3'b000, 0, 0, 0);
    add(0, 3'b111, 1, 5, 0, C_S, OA, 3'b001, 0, 3'b000, 0, 0, 0);
    add(0, 3'b000, 0, 6, 0, C_L, QA, 3'b000, 0, 3'b000, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, C_N, 0,  3'b000, 0, 3'b000, 0, 0, 0);
    // reset with loads outstanding; stale response afterwards flags err
    add(1, 3'b000, 0, 0, 1, C_N, 0,  3'b000, 0, 3'b000, 0, 1, 0);
    add(0, 3'b000, 0, 0, 0, C_N, 0,  3'b000, 0, 3'b000, 0, 1, 1);
    // memory rejects three times, then accepts with tag 5
    add(1, 3'b001, 0, 0, 0, C_N, 0,  3'b001, 0, 3'b000, 0, 1, 0);
    add(0, 3'b110, 1, 0, 0, C_L, QA, 3'b000, 0, 3'b000, 0, 0, 0);
    add(0, 3'b110, 1, 0, 0, C_L, QA, 3'b000, 0, 3'b000, 0, 0, 0);
    add(0, 3'b110, 1, 0, 0, C_L, QA, 3'b000, 0, 3'b000, 0, 0, 0);
    add(0, 3'b110, 1, 5, 0, C_L, QA, 3'b010, 0, 3'b000, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, C_L, KA, 3'b000, 0, 3'b000, 0, 0, 0);
    // K fills to MAX_OUT, V still served, one K response re-enables K
    add(1, 3'b110, 0, 0, 0, C_N, 0,  3'b010, 0, 3'b000, 0, 1, 0);
    add(0, 3'b010, 0, 1, 0, C_L, KA, 3'b010, 0, 3'b000, 0, 0, 0);
    add(0, 3'b010, 0, 2, 0, C_L, KA, 3'b010, 0, 3'b000, 0, 0, 0);
    add(0, 3'b010, 0, 3, 0, C_L, KA, 3'b010, 0, 3'b000, 0, 0, 0);
    add(0, 3'b110, 0, 4, 0, C_L, KA, 3'b100, 0, 3'b000, 0, 0, 0);
    add(0, 3'b010, 0, 6, 0, C_L, VA, 3'b000, 0, 3'b000, 0, 0, 0);
    add(0, 3'b010, 0, 0, 2, C_N, 0,  3'b000, 0, 3'b000, 0, 0, 0);
    add(0, 3'b010, 0, 0, 0, C_N, 0,  3'b010, 0, 3'b010, 2, 0, 0);
    add(0, 3'b000, 0, 7, 0, C_L, KA, 3'b000, 0, 3'b000, 0, 0, 0);
    // tag 7 returned (owner K) and re-accepted for Q in the same cycle
    add(0, 3'b001, 0, 0, 0, C_N, 0,  3'b001, 0, 3'b000, 0, 0, 0);
    add(0, 3'b000, 0, 7, 7, C_L, QA, 3'b000, 0, 3'b000, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, C_N, 0,  3'b000, 0, 3'b010, 7, 0, 0);
    add(0, 3'b000, 0, 0, 7, C_N, 0,  3'b000, 0, 3'b000, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, C_N, 0,  3'b000, 0, 3'b001, 7, 0, 0);
    // unknown tag 9: dropped, err sticky until reset
    add(0, 3'b000, 0, 0, 9, C_N, 0,  3'b000, 0, 3'b000, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, C_N, 0,  3'b000, 0, 3'b000, 0, 0, 1);
    add(0, 3'b000, 0, 0, 0, C_N, 0,  3'b000, 0, 3'b000, 0, 0, 1);
    add(1, 3'b000, 0, 0, 0, C_N, 0,  3'b000, 0, 3'b000, 0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      cur_vec = i;
      if (vq[i].rst_first) do_reset();
      drive(vq[i]);
      @(negedge clk);
      chk("cmd",    {62'h0, proc2mem_command}, {62'h0, vq[i].e_cmd});
      chk("addr",   {32'h0, proc2mem_addr},    {32'h0, vq[i].e_addr});
      chk("pdata",  proc2mem_data, (vq[i].e_cmd == C_S) ? ST_D : 64'h0);
      chk("ld_rdy", {61'h0, ld_req_rdy},       {61'h0, vq[i].e_ldrdy});
      chk("st_rdy", {63'h0, st_req_rdy},       {63'h0, vq[i].e_strdy});
      chk("rsp_vld", {61'h0, ld_rsp_vld},      {61'h0, vq[i].e_rsp});
      if (vq[i].e_rsp != 3'b000) chk("rsp_data", ld_rsp_data, mdata(vq[i].e_rtag));
      chk("idle",   {63'h0, idle},             {63'h0, vq[i].e_idle});
      chk("err",    {63'h0, err},              {63'h0, vq[i].e_err});
      @(posedge clk);
      #1;
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
